// File: rtl/bus_demux12.sv
// ---------------------------------------------------------------------------
// bus_demux12
//   Routes one request at a time from the core load/store port to one of two
//   targets. Port 0 is data RAM and port 1 is peripheral space. Addresses at or
//   above S1_BASE go to port 1. The block waits for the selected target's
//   response and returns it upstream as a one-cycle pulse. If no response comes
//   back within TIMEOUT cycles, it completes with an error instead.
//
// Valid/ready handshake (used on every channel here):
//   A transfer happens on a rising edge where valid and ready are both high.
//   Once valid is raised, the sender holds it and its payload stable until that
//   edge. Ready may depend combinationally on state but never on valid.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   req_valid / req_ready       upstream request handshake
//   req_addr/wdata/we/be        upstream request payload
//   sN_req_valid / sN_req_ready request handshake to target N (N = 0, 1)
//   sN_addr/wdata/we/be         registered payload to target N
//   sN_rsp_valid / sN_rsp_rdata response pulse and read data from target N
//   rsp_valid/rsp_rdata/rsp_err upstream completion pulse, data and error flag
//   fsm_state                   current controller state (0 idle, 1 req, 2 wait)
// ---------------------------------------------------------------------------
module bus_demux12 #(
    parameter logic [31:0] S1_BASE = 32'h4000_0000,
    parameter int          TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic        req_we,
    input  logic [3:0]  req_be,

    output logic        s0_req_valid,
    input  logic        s0_req_ready,
    output logic [31:0] s0_addr,
    output logic [31:0] s0_wdata,
    output logic        s0_we,
    output logic [3:0]  s0_be,
    input  logic        s0_rsp_valid,
    input  logic [31:0] s0_rsp_rdata,

    output logic        s1_req_valid,
    input  logic        s1_req_ready,
    output logic [31:0] s1_addr,
    output logic [31:0] s1_wdata,
    output logic        s1_we,
    output logic [3:0]  s1_be,
    input  logic        s1_rsp_valid,
    input  logic [31:0] s1_rsp_rdata,

    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,

    output logic [1:0]  fsm_state
);

    localparam int          CW       = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t        state, state_next;
    logic          sel, sel_next;
    logic [CW-1:0] cnt;

    // Single payload register shared by both ports; only sN_req_valid tells a
    // target that the payload is meant for it.
    logic [31:0] addr_q, wdata_q;
    logic        we_q;
    logic [3:0]  be_q;

    logic        accept;
    logic        sel_ready, sel_rsp;
    logic [31:0] sel_rdata;
    logic        complete, timeout;

    assign fsm_state = state;
    assign req_ready = (state == S_IDLE);
    assign accept    = req_valid && req_ready;

    // Only the selected target's signals are looked at; the other port is
    // ignored, including any stray response it produces.
    assign sel_ready = sel ? s1_req_ready : s0_req_ready;
    assign sel_rsp   = sel ? s1_rsp_valid : s0_rsp_valid;
    assign sel_rdata = sel ? s1_rsp_rdata : s0_rsp_rdata;

    always_comb begin
        state_next = state;
        sel_next   = sel;
        complete   = 1'b0;
        timeout    = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_next = S_REQ;
                    sel_next   = (req_addr >= S1_BASE);
                end
            end
            S_REQ: begin
                // A target may accept and respond in the same cycle.
                complete = sel_ready && sel_rsp;
                timeout  = (cnt == CNT_LAST) && !complete;
                if (complete || timeout) begin
                    state_next = S_IDLE;
                end else if (sel_ready) begin
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                complete = sel_rsp;
                timeout  = (cnt == CNT_LAST) && !complete;
                if (complete || timeout) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            sel   <= 1'b0;
        end else begin
            state <= state_next;
            sel   <= sel_next;
        end
    end

    // Timeout counter: cleared on accept, counts every cycle spent in REQ or
    // WAIT. The timeout fires at TIMEOUT-1, so the counter never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (accept) begin
            cnt <= '0;
        end else if (state != S_IDLE) begin
            cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            be_q    <= '0;
        end else if (accept) begin
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            we_q    <= req_we;
            be_q    <= req_be;
        end
    end

    // Target valids are registered from the next state, so a request is
    // presented for exactly the cycles the controller spends in REQ.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0_req_valid <= 1'b0;
            s1_req_valid <= 1'b0;
        end else begin
            s0_req_valid <= (state_next == S_REQ) && !sel_next;
            s1_req_valid <= (state_next == S_REQ) &&  sel_next;
        end
    end

    // Completion data holds its last value between pulses; rsp_valid alone
    // qualifies it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= complete || timeout;
            rsp_err   <= timeout;
            if (complete) begin
                rsp_rdata <= sel_rdata;
            end else if (timeout) begin
                rsp_rdata <= ERR_DATA;
            end
        end
    end

    assign s0_addr  = addr_q;
    assign s0_wdata = wdata_q;
    assign s0_we    = we_q;
    assign s0_be    = be_q;
    assign s1_addr  = addr_q;
    assign s1_wdata = wdata_q;
    assign s1_we    = we_q;
    assign s1_be    = be_q;

endmodule

// File: tb/tb_bus_demux12.sv
// ---------------------------------------------------------------------------
// tb_bus_demux12
//   Directed bench for bus_demux12 with default parameters (TIMEOUT = 16).
//   Inputs change 1 ns after a rising edge and outputs are sampled there too,
//   so every check sees values that settled after the preceding edge.
// ---------------------------------------------------------------------------
module tb_bus_demux12;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_we;
    logic [3:0]  req_be;
    logic        s0_req_valid, s0_req_ready;
    logic [31:0] s0_addr, s0_wdata;
    logic        s0_we;
    logic [3:0]  s0_be;
    logic        s0_rsp_valid;
    logic [31:0] s0_rsp_rdata;
    logic        s1_req_valid, s1_req_ready;
    logic [31:0] s1_addr, s1_wdata;
    logic        s1_we;
    logic [3:0]  s1_be;
    logic        s1_rsp_valid;
    logic [31:0] s1_rsp_rdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [1:0]  fsm_state;

    int n_total = 0;
    int n_pass  = 0;

    bus_demux12 dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_we       (req_we),
        .req_be       (req_be),
        .s0_req_valid (s0_req_valid),
        .s0_req_ready (s0_req_ready),
        .s0_addr      (s0_addr),
        .s0_wdata     (s0_wdata),
        .s0_we        (s0_we),
        .s0_be        (s0_be),
        .s0_rsp_valid (s0_rsp_valid),
        .s0_rsp_rdata (s0_rsp_rdata),
        .s1_req_valid (s1_req_valid),
        .s1_req_ready (s1_req_ready),
        .s1_addr      (s1_addr),
        .s1_wdata     (s1_wdata),
        .s1_we        (s1_we),
        .s1_be        (s1_be),
        .s1_rsp_valid (s1_rsp_valid),
        .s1_rsp_rdata (s1_rsp_rdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .fsm_state    (fsm_state)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic chkb(input string tag, input logic obs, input logic exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    task automatic drive_req(input logic [31:0] a, input logic [31:0] d,
                             input logic w, input logic [3:0] b);
        req_valid = 1'b1;
        req_addr  = a;
        req_wdata = d;
        req_we    = w;
        req_be    = b;
    endtask

    initial begin : stim
        int n;
        rst_n        = 1'b0;
        req_valid    = 1'b0;
        req_addr     = '0;
        req_wdata    = '0;
        req_we       = 1'b0;
        req_be       = '0;
        s0_req_ready = 1'b0;
        s0_rsp_valid = 1'b0;
        s0_rsp_rdata = '0;
        s1_req_ready = 1'b0;
        s1_rsp_valid = 1'b0;
        s1_rsp_rdata = '0;

        // ---- reset state ----
        step();
        step();
        chkb("rst_req_ready", req_ready, 1'b1);
        chkb("rst_rsp_valid", rsp_valid, 1'b0);
        chkb("rst_rsp_err", rsp_err, 1'b0);
        chk ("rst_rsp_rdata", rsp_rdata, 32'h0);
        chkb("rst_s0_valid", s0_req_valid, 1'b0);
        chkb("rst_s1_valid", s1_req_valid, 1'b0);
        chk ("rst_s0_addr", s0_addr, 32'h0);
        chk ("rst_state", 32'(fsm_state), 32'd0);
        rst_n = 1'b1;
        step();

        // ---- read to RAM, one-cycle response ----
        s0_req_ready = 1'b1;
        drive_req(32'h0000_0010, 32'h0, 1'b0, 4'hF);
        step();                                 // cycle E0+1
        req_valid = 1'b0;
        chkb("rd_s0_valid", s0_req_valid, 1'b1);
        chkb("rd_s1_valid", s1_req_valid, 1'b0);
        chk ("rd_s0_addr", s0_addr, 32'h0000_0010);
        chkb("rd_s0_we", s0_we, 1'b0);
        chkb("rd_req_ready_busy", req_ready, 1'b0);
        step();                                 // E0+2: waiting
        chkb("rd_s0_valid_drop", s0_req_valid, 1'b0);
        chkb("rd_no_early_rsp", rsp_valid, 1'b0);
        s0_rsp_valid = 1'b1;
        s0_rsp_rdata = 32'hABCE_DF12;
        step();                                 // E0+3: completion
        s0_rsp_valid = 1'b0;
        chkb("rd_rsp_valid", rsp_valid, 1'b1);
        chk ("rd_rsp_rdata", rsp_rdata, 32'hABCE_DF12);
        chkb("rd_rsp_err", rsp_err, 1'b0);
        chkb("rd_ready_in_pulse", req_ready, 1'b1);
        step();
        chkb("rd_pulse_one_cycle", rsp_valid, 1'b0);
        s0_req_ready = 1'b0;

        // ---- write to peripheral, 3 stall cycles ----
        drive_req(32'h4000_0004, 32'h1234_5678, 1'b1, 4'hF);
        step();
        req_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chkb("wr_s1_valid_held", s1_req_valid, 1'b1);
            chkb("wr_s0_valid_low", s0_req_valid, 1'b0);
            chk ("wr_s1_addr", s1_addr, 32'h4000_0004);
            chk ("wr_s1_wdata", s1_wdata, 32'h1234_5678);
            chkb("wr_s1_we", s1_we, 1'b1);
            chk ("wr_s1_be", 32'(s1_be), 32'hF);
            if (i == 3) s1_req_ready = 1'b1;
            step();
        end
        s1_req_ready = 1'b0;
        chkb("wr_s1_valid_drop", s1_req_valid, 1'b0);
        chkb("wr_no_early_rsp", rsp_valid, 1'b0);
        s1_rsp_valid = 1'b1;
        step();
        s1_rsp_valid = 1'b0;
        chkb("wr_rsp_valid", rsp_valid, 1'b1);
        chkb("wr_rsp_err", rsp_err, 1'b0);
        step();

        // ---- boundary below S1_BASE, zero-latency target ----
        drive_req(32'h3FFF_FFFC, 32'h0, 1'b0, 4'h3);
        step();                                 // E0+1
        req_valid = 1'b0;
        chkb("bnd_lo_s0_valid", s0_req_valid, 1'b1);
        chkb("bnd_lo_s1_valid", s1_req_valid, 1'b0);
        s0_req_ready = 1'b1;
        s0_rsp_valid = 1'b1;
        s0_rsp_rdata = 32'h1111_1111;
        step();                                 // E0+2
        s0_req_ready = 1'b0;
        s0_rsp_valid = 1'b0;
        chkb("zl_rsp_valid", rsp_valid, 1'b1);
        chk ("zl_rsp_rdata", rsp_rdata, 32'h1111_1111);
        chkb("zl_rsp_err", rsp_err, 1'b0);
        chkb("b2b_req_ready", req_ready, 1'b1);
        // back-to-back request in the pulse cycle, exactly at S1_BASE
        drive_req(32'h4000_0000, 32'h0, 1'b0, 4'hF);
        step();
        req_valid = 1'b0;
        chkb("bnd_hi_s1_valid", s1_req_valid, 1'b1);
        chkb("bnd_hi_s0_valid", s0_req_valid, 1'b0);
        chk ("bnd_hi_s1_addr", s1_addr, 32'h4000_0000);
        s1_req_ready = 1'b1;
        step();                                 // now waiting on s1
        s1_req_ready = 1'b0;
        s0_rsp_valid = 1'b1;                    // wrong port
        s0_rsp_rdata = 32'hBAD0_BAD0;
        step();
        s0_rsp_valid = 1'b0;
        chkb("wrong_port_ignored", rsp_valid, 1'b0);
        s1_rsp_valid = 1'b1;
        s1_rsp_rdata = 32'h2222_2222;
        step();
        s1_rsp_valid = 1'b0;
        chkb("b2b_rsp_valid", rsp_valid, 1'b1);
        chk ("b2b_rsp_rdata", rsp_rdata, 32'h2222_2222);
        step();

        // ---- timeout: s0 accepts but never responds ----
        s0_req_ready = 1'b1;
        drive_req(32'h0000_0100, 32'h0, 1'b0, 4'hF);
        step();                                 // E0+1
        req_valid = 1'b0;
        n = 1;
        while (!rsp_valid && n < 40) begin
            step();
            n++;
        end
        chk ("to_latency", 32'(n), 32'd17);
        chkb("to_rsp_valid", rsp_valid, 1'b1);
        chkb("to_rsp_err", rsp_err, 1'b1);
        chk ("to_rsp_rdata", rsp_rdata, 32'hDEAD_BEEF);
        step();
        chkb("to_pulse_one_cycle", rsp_valid, 1'b0);
        s0_rsp_valid = 1'b1;                    // late response in idle
        s0_rsp_rdata = 32'h5555_5555;
        step();
        s0_rsp_valid = 1'b0;
        chkb("late_rsp_ignored", rsp_valid, 1'b0);
        step();
        chkb("late_rsp_ignored2", rsp_valid, 1'b0);
        s0_req_ready = 1'b0;

        // ---- reset while waiting ----
        s0_req_ready = 1'b1;
        drive_req(32'h0000_0200, 32'hCAFE_0001, 1'b1, 4'h1);
        step();
        req_valid = 1'b0;
        step();                                 // waiting on s0
        s0_req_ready = 1'b0;
        chk ("mid_state_wait", 32'(fsm_state), 32'd2);
        rst_n = 1'b0;
        #1;
        chk ("mr_s0_addr", s0_addr, 32'h0);
        chk ("mr_s0_wdata", s0_wdata, 32'h0);
        chk ("mr_rsp_rdata", rsp_rdata, 32'h0);
        chkb("mr_rsp_valid", rsp_valid, 1'b0);
        chk ("mr_state", 32'(fsm_state), 32'd0);
        step();
        rst_n = 1'b1;
        s0_rsp_valid = 1'b1;                    // response to the aborted request
        s0_rsp_rdata = 32'h6666_6666;
        step();
        s0_rsp_valid = 1'b0;
        chkb("mr_no_rsp", rsp_valid, 1'b0);
        step();
        chkb("mr_no_rsp2", rsp_valid, 1'b0);
        drive_req(32'h0000_0300, 32'h0, 1'b0, 4'hF);
        step();
        req_valid = 1'b0;
        chkb("post_rst_s0_valid", s0_req_valid, 1'b1);
        s0_req_ready = 1'b1;
        s0_rsp_valid = 1'b1;
        s0_rsp_rdata = 32'h3333_3333;
        step();
        s0_req_ready = 1'b0;
        s0_rsp_valid = 1'b0;
        chkb("post_rst_rsp_valid", rsp_valid, 1'b1);
        chk ("post_rst_rsp_rdata", rsp_rdata, 32'h3333_3333);
        chkb("post_rst_rsp_err", rsp_err, 1'b0);
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Guard against a stalled run.
    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: run did not finish, observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/bus_demux12.md
# bus_demux12

Single-outstanding 1:2 request router between the core load/store port and two memory-mapped targets: data RAM (port 0) and peripheral space (port 1). It accepts one upstream request, steers it to the selected target by address, and waits for that target's response. It then returns the response upstream as a one-cycle pulse. A bounded timeout converts a missing response into an error completion, so a dead target never hangs the core.

## Interface
Parameters:
- `S1_BASE`, default `32'h4000_0000`: addresses `>= S1_BASE` route to port 1; all others route to port 0.
- `TIMEOUT`, default `16`: maximum cycles spent in REQ+WAIT before an error completion. Legal range is `TIMEOUT >= 2`.

Ports:
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous active-low reset
- `req_valid`  in  1  upstream request valid
- `req_ready`  out  1  upstream request accepted when high with `req_valid`
- `req_addr`  in  32  byte address
- `req_wdata`  in  32  write data
- `req_we`  in  1  1 = write, 0 = read
- `req_be`  in  4  byte enables
- `sN_req_valid`  out  1  request to target N (N = 0, 1)
- `sN_req_ready`  in  1  target N accepts request
- `sN_addr` / `sN_wdata` / `sN_we` / `sN_be`  out  32/32/1/4  registered payload to target N
- `sN_rsp_valid`  in  1  target N response pulse (read data or write ack)
- `sN_rsp_rdata`  in  32  target N read data
- `rsp_valid`  out  1  upstream completion pulse, exactly one cycle
- `rsp_rdata`  out  32  completion data
- `rsp_err`  out  1  completion is a timeout error

## Operation
States:
- **IDLE**
  - `req_ready = (state == IDLE)`. This is combinational, so it is also high during reset. Upstream must not assert `req_valid` while `rst_n = 0`.
  - On `req_valid && req_ready`: register addr, wdata, we, be. Register `sel = (req_addr >= S1_BASE)`. Clear the counter. Go to REQ.
- **REQ**
  - `s{sel}_req_valid = 1` with the registered payload. `s{!sel}_req_valid = 0`.
  - On `s{sel}_req_ready = 1`:
    - If `s{sel}_rsp_valid = 1` in the same cycle, complete (zero-latency target).
    - Otherwise go to WAIT.
  - Payload and `s_req_valid` are stable until accepted.
- **WAIT**
  - `s_req_valid = 0`.
  - On `s{sel}_rsp_valid`: complete.
- **Complete:** next edge sets `rsp_valid = 1`, `rsp_rdata = s{sel}_rsp_rdata`, `rsp_err = 0`, and state goes to IDLE.
- **Timeout:**
  - The counter increments every cycle in REQ and WAIT.
  - If it equals `TIMEOUT-1` and no completion occurs that cycle, the next edge sets `rsp_valid = 1`, `rsp_err = 1`, `rsp_rdata = 32'hDEAD_BEEF`, and state goes to IDLE.
  - A completion in the same cycle wins over the timeout.
- **Ignored inputs:**
  - Responses from the non-selected target are ignored.
  - Responses arriving in IDLE are ignored, including late responses after a timeout.
- **Counter width:** `$clog2(TIMEOUT+1)`. Saturation is never reached, because the timeout fires first.
- **Between transactions:** payload registers hold their last value. Only `sN_req_valid` qualifies them.

## Timing
- **Reset values:**
  - All registered outputs are 0: `sN_req_valid`, `sN_addr`/`wdata`/`we`/`be`, `rsp_valid`, `rsp_rdata`, `rsp_err`.
  - State is IDLE and the counter is 0.
  - Reset mid-transaction aborts immediately. No `rsp_valid` is produced for the aborted request.
- **Best-case latency:** request accepted at edge E0, `s_req_valid` high in cycle E0+1. If the target is ready and responds in that same cycle, `rsp_valid` is high in cycle E0+2. A one-cycle target response after accept gives E0+3.
- **Pulse and back-to-back:** `rsp_valid` is high for exactly one cycle. `req_ready` is high in that same cycle (state is IDLE), so back-to-back requests are allowed. Peak throughput is one transaction per 2 cycles.
- **Timeout timing:** the error pulse appears exactly `TIMEOUT+1` cycles after the accept edge.

## Test plan
- **Read to RAM:** `req_addr = 32'h0000_0010`, s0 ready immediately, s0 responds 1 cycle later with `32'hABCE_DF12` -> `s0_req_valid` for 1 cycle, `s1_req_valid` stays 0, `rsp_valid` pulse with `rsp_rdata = 32'hABCE_DF12`, `rsp_err = 0`.
- **Write to peripheral:** `req_addr = 32'h4000_0004`, `wdata = 32'h1234_5678`, `be = 4'hF`, s1 stalls `req_ready` for 3 cycles -> payload held stable on s1 for 4 cycles, ack yields `rsp_valid` with `rsp_err = 0`.
- **Boundary decode:** `32'h3FFF_FFFC` -> port 0; `32'h4000_0000` -> port 1.
- **Timeout (`TIMEOUT = 16`):** s0 never responds -> `rsp_valid` with `rsp_err = 1` and `rsp_rdata = 32'hDEAD_BEEF` exactly 17 cycles after accept. A later s0 response is ignored (no extra pulse).
- **Same-cycle and back-to-back:**
  - Zero-latency target (`req_ready` and `rsp_valid` in the same cycle) completes in 2 cycles.
  - A second request issued in the `rsp_valid` cycle is accepted.
  - A response from the wrong port during WAIT is ignored.
- **Reset mid-WAIT:** pulse `rst_n` low while in WAIT -> all outputs 0 asynchronously, no `rsp_valid` after release, next request completes normally.
